// File: rtl/timer_pkg.sv
// timer_pkg
// Shared types and constants for the mm:ss BCD countdown timer.
//   timer_state_t : controller states (IDLE, RUN, PAUSE, DONE)
//   bcd_t         : one 4-bit BCD digit
//   BCD_MAX       : largest BCD digit value, wrap value for units and minutes
//   SEC_TENS_MAX  : wrap value for the seconds-tens digit
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } timer_state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX      = 4'd9;
  localparam bcd_t SEC_TENS_MAX = 4'd5;

endpackage

// File: rtl/bcd_digit_down.sv
// bcd_digit_down
// One BCD digit of a down-counter, purely combinational.
// Ports:
//   digit      in  4  current digit value
//   dec_en     in  1  decrement this digit
//   wrap_val   in  4  value loaded when decrementing from 0
//   next_digit out 4  digit value after the (optional) decrement
//   borrow     out 1  high when the digit wrapped, i.e. the next digit up must decrement
module bcd_digit_down
  import timer_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       dec_en,
  input  logic [3:0] wrap_val,
  output logic [3:0] next_digit,
  output logic       borrow
);

  // Decrement with wrap; the borrow only fires when this digit actually decremented from 0.
  always_comb begin
    next_digit = digit;
    borrow     = 1'b0;
    if (dec_en) begin
      if (digit == 4'd0) begin
        next_digit = wrap_val;
        borrow     = 1'b1;
      end else begin
        next_digit = digit - 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_countdown_timer.sv
// bcd_countdown_timer
// Keypad entry plus mm:ss BCD countdown feeding the 7-segment decoder.
// Digits are shifted in while idle; the value counts down once every TICKS_PER_SEC
// tick pulses while running and stops in DONE at 0:00.
// Parameters:
//   TICKS_PER_SEC  tick pulses per decrement (1 = every tick)
// Ports:
//   clk          in  1  system clock, rising edge
//   reset        in  1  asynchronous active-high reset
//   tick         in  1  one-cycle enable pulse from the prescaler
//   digit        in  4  BCD keypad digit
//   digit_valid  in  1  strobe qualifying digit
//   start        in  1  start/resume request
//   stop         in  1  pause request
//   clear        in  1  synchronous clear to 0:00 / IDLE
//   sec_ones     out 4  seconds units
//   sec_tens     out 4  seconds tens
//   mins         out 4  minutes
//   running      out 1  high in RUN
//   done         out 1  high in DONE
// Configuration macro:
//   BCD_TIMER_DIGIT_CHECK_EN  when defined, keypad digits above 9 are ignored
module bcd_countdown_timer
  import timer_pkg::*;
#(
  parameter int TICKS_PER_SEC = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic [3:0] digit,
  input  logic       digit_valid,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] mins,
  output logic       running,
  output logic       done
);

  localparam int CW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICKS_PER_SEC - 1);

  timer_state_t state, state_next;
  bcd_t         ones_next, tens_next, mins_next;
  logic [CW-1:0] cnt, cnt_next;

  logic dec_en;
  bcd_t ones_dec, tens_dec, mins_dec;
  logic ones_borrow, tens_borrow, mins_borrow;
  logic digit_ok;
  logic value_nonzero;
  logic dec_to_zero;

  // Three chained digit decrementers: units borrow into tens, tens borrow into minutes.
  bcd_digit_down u_ones (
    .digit      (sec_ones),
    .dec_en     (dec_en),
    .wrap_val   (BCD_MAX),
    .next_digit (ones_dec),
    .borrow     (ones_borrow)
  );

  bcd_digit_down u_tens (
    .digit      (sec_tens),
    .dec_en     (ones_borrow),
    .wrap_val   (SEC_TENS_MAX),
    .next_digit (tens_dec),
    .borrow     (tens_borrow)
  );

  bcd_digit_down u_mins (
    .digit      (mins),
    .dec_en     (tens_borrow),
    .wrap_val   (BCD_MAX),
    .next_digit (mins_dec),
    .borrow     (mins_borrow)
  );

`ifdef BCD_TIMER_DIGIT_CHECK_EN
  assign digit_ok = (digit <= BCD_MAX);
`else
  assign digit_ok = 1'b1;
`endif

  assign value_nonzero = (sec_ones != 4'd0) || (sec_tens != 4'd0) || (mins != 4'd0);
  // A minutes borrow would mean underflow past 0:00; treat it as reaching zero so the
  // counter saturates rather than wrapping to 9:59.
  assign dec_to_zero = ((ones_dec == 4'd0) && (tens_dec == 4'd0) && (mins_dec == 4'd0))
                       || mins_borrow;

  // Next-state and next-digit logic. The if/else chain encodes the input priority:
  // clear, then stop, then start, then digit entry or tick.
  always_comb begin
    state_next = state;
    ones_next  = sec_ones;
    tens_next  = sec_tens;
    mins_next  = mins;
    cnt_next   = cnt;
    dec_en     = 1'b0;
    if (clear) begin
      state_next = IDLE;
      ones_next  = 4'd0;
      tens_next  = 4'd0;
      mins_next  = 4'd0;
      cnt_next   = '0;
    end else if (stop) begin
      if (state == RUN) begin
        state_next = PAUSE;
      end
    end else if (start && ((state == IDLE && value_nonzero) || state == PAUSE)) begin
      // A fresh run restarts the prescaler; resuming from PAUSE keeps its count.
      if (state == IDLE) begin
        cnt_next = '0;
      end
      state_next = RUN;
    end else begin
      case (state)
        IDLE: begin
          if (digit_valid && digit_ok) begin
            mins_next = sec_tens;
            tens_next = sec_ones;
            ones_next = digit;
          end
        end
        RUN: begin
          if (tick) begin
            if (cnt == CNT_LAST) begin
              cnt_next = '0;
              dec_en   = 1'b1;
              if (dec_to_zero) begin
                state_next = DONE;
                ones_next  = 4'd0;
                tens_next  = 4'd0;
                mins_next  = 4'd0;
              end else begin
                ones_next = ones_dec;
                tens_next = tens_dec;
                mins_next = mins_dec;
              end
            end else begin
              cnt_next = cnt + 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // State, digits, prescaler and the status flags all live in registers; the flags
  // are decoded from the next state so they line up with the digits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      sec_ones <= 4'd0;
      sec_tens <= 4'd0;
      mins     <= 4'd0;
      cnt      <= '0;
      running  <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_next;
      sec_ones <= ones_next;
      sec_tens <= tens_next;
      mins     <= mins_next;
      cnt      <= cnt_next;
      running  <= (state_next == RUN);
      done     <= (state_next == DONE);
    end
  end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// tb_bcd_countdown_timer
// Directed testbench for bcd_countdown_timer with TICKS_PER_SEC = 1.
module tb_bcd_countdown_timer;

  logic       clk;
  logic       reset;
  logic       tick;
  logic [3:0] digit;
  logic       digit_valid;
  logic       start;
  logic       stop;
  logic       clear;
  logic [3:0] sec_ones;
  logic [3:0] sec_tens;
  logic [3:0] mins;
  logic       running;
  logic       done;

  int checks = 0;
  int errors = 0;

  bcd_countdown_timer #(.TICKS_PER_SEC(1)) dut (
    .clk         (clk),
    .reset       (reset),
    .tick        (tick),
    .digit       (digit),
    .digit_valid (digit_valid),
    .start       (start),
    .stop        (stop),
    .clear       (clear),
    .sec_ones    (sec_ones),
    .sec_tens    (sec_tens),
    .mins        (mins),
    .running     (running),
    .done        (done)
  );

  // Free-running 100 MHz clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle of inputs, let one rising edge capture them, then return 1 ns after
  // that edge with all strobes low again.
  task automatic applyStimulus(input logic [3:0] d, input logic dv, input logic st,
                               input logic sp, input logic cl, input logic tk);
    digit       = d;
    digit_valid = dv;
    start       = st;
    stop        = sp;
    clear       = cl;
    tick        = tk;
    @(posedge clk);
    #1;
    digit_valid = 1'b0;
    start       = 1'b0;
    stop        = 1'b0;
    clear       = 1'b0;
    tick        = 1'b0;
  endtask

  // Compare every output in one shot against the hand-computed m:ts, running, done.
  task automatic checkOutput(input string tag, input logic [3:0] m, input logic [3:0] t,
                             input logic [3:0] o, input logic r, input logic d);
    logic [13:0] observed;
    logic [13:0] expected;
    observed = {mins, sec_tens, sec_ones, running, done};
    expected = {m, t, o, r, d};
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d:%0d%0d running=%0b done=%0b, expected %0d:%0d%0d running=%0b done=%0b",
             tag, mins, sec_tens, sec_ones, running, done, m, t, o, r, d);
    end
  endtask

  task automatic key(input logic [3:0] d);
    applyStimulus(d, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pressStart();
    applyStimulus(4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pressStop();
    applyStimulus(4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic pressClear();
    applyStimulus(4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic doTick();
    applyStimulus(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // Directed sequence
  initial begin
    reset       = 1'b1;
    tick        = 1'b0;
    digit       = 4'd0;
    digit_valid = 1'b0;
    start       = 1'b0;
    stop        = 1'b0;
    clear       = 1'b0;
    #22;
    reset = 1'b0;
    checkOutput("reset_state", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;

    // Entry 1,3,0 then count 1:30 -> 1:28
    key(4'd1);
    checkOutput("shift_1", 4'd0, 4'd0, 4'd1, 1'b0, 1'b0);
    key(4'd3);
    checkOutput("shift_13", 4'd0, 4'd1, 4'd3, 1'b0, 1'b0);
    key(4'd0);
    checkOutput("shift_130", 4'd1, 4'd3, 4'd0, 1'b0, 1'b0);
    pressStart();
    checkOutput("start_130", 4'd1, 4'd3, 4'd0, 1'b1, 1'b0);
    doTick();
    checkOutput("tick_129", 4'd1, 4'd2, 4'd9, 1'b1, 1'b0);
    doTick();
    checkOutput("tick_128", 4'd1, 4'd2, 4'd8, 1'b1, 1'b0);
    key(4'd7);
    checkOutput("digit_in_run", 4'd1, 4'd2, 4'd8, 1'b1, 1'b0);
    pressClear();
    checkOutput("clear_run", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);

    // 0:02 down to DONE, start ignored in DONE
    key(4'd2);
    pressStart();
    doTick();
    checkOutput("tick_001", 4'd0, 4'd0, 4'd1, 1'b1, 1'b0);
    doTick();
    checkOutput("reach_000", 4'd0, 4'd0, 4'd0, 1'b0, 1'b1);
    pressStart();
    checkOutput("start_in_done", 4'd0, 4'd0, 4'd0, 1'b0, 1'b1);
    doTick();
    checkOutput("tick_in_done", 4'd0, 4'd0, 4'd0, 1'b0, 1'b1);
    pressClear();
    checkOutput("clear_done", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);

    // Start at 0:00 is ignored
    pressStart();
    checkOutput("start_at_zero", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);

    // 1:00 -> 0:59, and a tick in the start cycle does not decrement
    key(4'd1);
    key(4'd0);
    key(4'd0);
    checkOutput("load_100", 4'd1, 4'd0, 4'd0, 1'b0, 1'b0);
    applyStimulus(4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("start_plus_tick", 4'd1, 4'd0, 4'd0, 1'b1, 1'b0);
    doTick();
    checkOutput("borrow_059", 4'd0, 4'd5, 4'd9, 1'b1, 1'b0);
    pressClear();

    // 0:10 with pause / resume
    key(4'd1);
    key(4'd0);
    pressStart();
    doTick();
    checkOutput("tick_009", 4'd0, 4'd0, 4'd9, 1'b1, 1'b0);
    pressStop();
    checkOutput("paused", 4'd0, 4'd0, 4'd9, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      doTick();
    end
    checkOutput("pause_hold", 4'd0, 4'd0, 4'd9, 1'b0, 1'b0);
    key(4'd5);
    checkOutput("digit_in_pause", 4'd0, 4'd0, 4'd9, 1'b0, 1'b0);
    pressStart();
    checkOutput("resume", 4'd0, 4'd0, 4'd9, 1'b1, 1'b0);
    doTick();
    checkOutput("tick_008", 4'd0, 4'd0, 4'd8, 1'b1, 1'b0);
    applyStimulus(4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("stop_plus_tick", 4'd0, 4'd0, 4'd8, 1'b0, 1'b0);
    pressClear();

    // 9:99 keeps its tens digit until the first borrow
    key(4'd9);
    key(4'd9);
    key(4'd9);
    pressStart();
    doTick();
    checkOutput("tick_998", 4'd9, 4'd9, 4'd8, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      doTick();
    end
    checkOutput("tick_990", 4'd9, 4'd9, 4'd0, 1'b1, 1'b0);
    doTick();
    checkOutput("tick_989", 4'd9, 4'd8, 4'd9, 1'b1, 1'b0);
    pressClear();

    // 2:00 -> 1:59 with tens wrapping to 5
    key(4'd2);
    key(4'd0);
    key(4'd0);
    pressStart();
    doTick();
    checkOutput("tick_159", 4'd1, 4'd5, 4'd9, 1'b1, 1'b0);
    pressClear();

    // 5:55 cleared mid-count, then async reset between edges
    key(4'd5);
    key(4'd5);
    key(4'd5);
    pressStart();
    doTick();
    checkOutput("tick_554", 4'd5, 4'd5, 4'd4, 1'b1, 1'b0);
    pressClear();
    checkOutput("clear_mid_run", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    key(4'd5);
    key(4'd5);
    key(4'd5);
    pressStart();
    doTick();
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_reset", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("after_reset", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);

`ifdef BCD_TIMER_DIGIT_CHECK_EN
    // Non-BCD keypad digit is dropped
    key(4'd4);
    key(4'd12);
    checkOutput("digit_12_ignored", 4'd0, 4'd0, 4'd4, 1'b0, 1'b0);
    key(4'd7);
    checkOutput("digit_check_047", 4'd0, 4'd4, 4'd7, 1'b0, 1'b0);
    pressClear();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
